// File: rtl/timer_digit_loader.sv
// Keypad digit collector for the timer down-counter chain: shifts BCD digits in calculator-style,
// clamps seconds-tens at commit and pulses load for LOAD_CYCLES clocks; entry is locked while busy.
module timer_digit_loader #(
  parameter int unsigned LOAD_CYCLES = 1,
  parameter int unsigned MAX_TENS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       commit,
  input  logic       timer_busy,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       load,
  output logic [1:0] digit_count,
  output logic       entry_active,
  output logic       key_err
);

  localparam logic [3:0] LoadLen = 4'(LOAD_CYCLES);
  localparam logic [3:0] MaxTens = 4'(MAX_TENS);
  localparam logic [3:0] KeyClear = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] load_cnt_q, load_cnt_d;
  logic       key_err_q, key_err_d;
  logic       key_prev_q;
  logic       commit_prev_q;

  logic key_edge;
  logic commit_edge;
  logic is_digit;
  logic is_clear;

  // Previous-sample registers reset high so a level held through reset is not a press.
  assign key_edge    = key_valid & ~key_prev_q;
  assign commit_edge = commit & ~commit_prev_q;
  assign is_digit    = (key_code <= 4'd9);
  assign is_clear    = (key_code == KeyClear);

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    tens_d     = tens_q;
    units_d    = units_q;
    cnt_d      = cnt_q;
    load_cnt_d = load_cnt_q;
    key_err_d  = 1'b0;

    case (state_q)
      IDLE, ENTRY: begin
        if (!timer_busy) begin
          // Commit takes priority over a key edge on the same clock.
          if (commit_edge && (state_q == ENTRY) && (cnt_q != 2'd0)) begin
            state_d    = LOAD;
            load_cnt_d = LoadLen;
            if (tens_q > MaxTens) begin
              tens_d = MaxTens;
            end
          end else if (key_edge) begin
            if (is_digit) begin
              min_d   = tens_q;
              tens_d  = units_q;
              units_d = key_code;
              cnt_d   = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
              state_d = ENTRY;
            end else if (is_clear) begin
              min_d   = 4'd0;
              tens_d  = 4'd0;
              units_d = 4'd0;
              cnt_d   = 2'd0;
              state_d = IDLE;
            end else begin
              key_err_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        if (load_cnt_q <= 4'd1) begin
          state_d    = IDLE;
          cnt_d      = 2'd0;
          load_cnt_d = 4'd0;
        end else begin
          load_cnt_d = load_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      min_q         <= 4'd0;
      tens_q        <= 4'd0;
      units_q       <= 4'd0;
      cnt_q         <= 2'd0;
      load_cnt_q    <= 4'd0;
      key_err_q     <= 1'b0;
      key_prev_q    <= 1'b1;
      commit_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      min_q         <= min_d;
      tens_q        <= tens_d;
      units_q       <= units_d;
      cnt_q         <= cnt_d;
      load_cnt_q    <= load_cnt_d;
      key_err_q     <= key_err_d;
      key_prev_q    <= key_valid;
      commit_prev_q <= commit;
    end
  end

  assign min_units    = min_q;
  assign sec_tens     = tens_q;
  assign sec_units    = units_q;
  assign digit_count  = cnt_q;
  assign load         = (state_q == LOAD);
  assign entry_active = (state_q == ENTRY);
  assign key_err      = key_err_q;

endmodule
